// File: rtl/handshake_arbiter.sv
// Two-requester round-robin arbiter onto one valid/ready slave channel.
// Grants are held for up to MAX_BURST beats; every release costs one idle cycle.
module handshake_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_valid,
  output logic              m1_ready,
  output logic [DATA_W-1:0] s_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [1:0]        grant,
  output logic [3:0]        beat_cnt
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  // Count value at which the next transfer is the last beat of the burst.
  localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    grant        = 2'b00;
    s_valid      = 1'b0;
    s_data       = '0;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie, the requester that did not own the channel last wins.
        if (m0_valid && (!m1_valid || last_owner_q)) begin
          state_d      = StGnt0;
          last_owner_d = 1'b0;
          beat_cnt_d   = '0;
        end else if (m1_valid) begin
          state_d      = StGnt1;
          last_owner_d = 1'b1;
          beat_cnt_d   = '0;
        end
      end
      StGnt0: begin
        grant    = 2'b01;
        s_data   = m0_data;
        s_valid  = m0_valid;
        m0_ready = s_ready;
        if (!m0_valid) begin
          state_d = StIdle;
        end else if (s_ready) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_q == BurstLast) state_d = StIdle;
        end
      end
      StGnt1: begin
        grant    = 2'b10;
        s_data   = m1_data;
        s_valid  = m1_valid;
        m1_ready = s_ready;
        if (!m1_valid) begin
          state_d = StIdle;
        end else if (s_ready) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_q == BurstLast) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed vector bench for handshake_arbiter: table of per-cycle stimulus and
// expected outputs, a transfer scoreboard, and hand sequences for reset and MAX_BURST=1.
module tb_handshake_arbiter;

  typedef struct {
    logic        rst, v0, v1, sr;
    logic [31:0] d0, d1;
    logic [1:0]  grant;
    logic        sv;
    logic [31:0] sd;
    logic        r0, r1;
    int          cnt;  // -1: not checked
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_data = '0, m1_data = '0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0, s_ready = 1'b0;
  logic        m0_ready, m1_ready, s_valid;
  logic [31:0] s_data;
  logic [1:0]  grant;
  logic [3:0]  beat_cnt;

  logic        b_m0_ready, b_m1_ready, b_s_valid;
  logic [31:0] b_s_data;
  logic [1:0]  b_grant;
  logic [3:0]  b_beat_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp0[$], exp1[$], got0[$], got1[$];
  int n_m = 0, n_s = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  handshake_arbiter #(.DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_data(m0_data), .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m1_data(m1_data), .m1_valid(m1_valid), .m1_ready(m1_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .grant(grant), .beat_cnt(beat_cnt)
  );

  handshake_arbiter #(.DATA_W(32), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .m0_data(m0_data), .m0_valid(m0_valid), .m0_ready(b_m0_ready),
    .m1_data(m1_data), .m1_valid(m1_valid), .m1_ready(b_m1_ready),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(s_ready),
    .grant(b_grant), .beat_cnt(b_beat_cnt)
  );

  function automatic logic [31:0] a(int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] b(int i);
    return 32'hB000_0000 + 32'(i);
  endfunction

  function automatic vec_t mk(logic r, logic v0, logic v1, logic sr, logic [31:0] d0,
                              logic [31:0] d1, logic [1:0] g, logic sv, logic [31:0] sd,
                              logic r0, logic r1, int cnt);
    vec_t v;
    v.rst = r; v.v0 = v0; v.v1 = v1; v.sr = sr; v.d0 = d0; v.d1 = d1;
    v.grant = g; v.sv = sv; v.sd = sd; v.r0 = r0; v.r1 = r1; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Record transfers on both sides for the scoreboard.
  task automatic sample();
    if (m0_valid && m0_ready) begin exp0.push_back(m0_data); n_m++; end
    if (m1_valid && m1_ready) begin exp1.push_back(m1_data); n_m++; end
    if (s_valid && s_ready) begin
      n_s++;
      if (grant == 2'b01) got0.push_back(s_data);
      else if (grant == 2'b10) got1.push_back(s_data);
    end
  endtask

  initial begin
    // rst v0 v1 sr d0 d1 | grant sv sd r0 r1 cnt
    vecs.push_back(mk(1, 1, 0, 1, a(0), b(0), 2'b00, 0, 0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, a(0), b(0), 2'b00, 0, 0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, a(0), b(0), 2'b01, 1, a(0), 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, a(1), b(0), 2'b01, 1, a(1), 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, a(2), b(0), 2'b01, 1, a(2), 1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 1, a(3), b(0), 2'b01, 1, a(3), 1, 0, 3));
    vecs.push_back(mk(0, 1, 0, 1, a(4), b(0), 2'b00, 0, 0,    0, 0, -1));
    vecs.push_back(mk(0, 1, 0, 1, a(4), b(0), 2'b01, 1, a(4), 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, a(5), b(0), 2'b01, 0, a(5), 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, a(5), b(0), 2'b00, 0, 0,    0, 0, -1));
    vecs.push_back(mk(0, 0, 1, 1, a(5), b(0), 2'b10, 1, b(0), 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, a(5), b(1), 2'b10, 1, b(1), 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, a(5), b(2), 2'b10, 0, b(2), 0, 1, 2));
    vecs.push_back(mk(0, 1, 0, 1, a(5), b(2), 2'b00, 0, 0,    0, 0, -1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 0, 0, a(5), b(2), 2'b01, 1, a(5), 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, a(5), b(2), 2'b01, 1, a(5), 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, a(6), b(2), 2'b01, 1, a(6), 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, a(7), b(2), 2'b01, 1, a(7), 1, 0, 2));
    vecs.push_back(mk(0, 1, 1, 1, a(8), b(2), 2'b01, 1, a(8), 1, 0, 3));
    vecs.push_back(mk(0, 1, 1, 1, a(9), b(2), 2'b00, 0, 0,    0, 0, -1));
    vecs.push_back(mk(0, 1, 1, 1, a(9), b(2), 2'b10, 1, b(2), 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, a(9), b(3), 2'b10, 1, b(3), 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, a(9), b(4), 2'b10, 1, b(4), 0, 1, 2));
    vecs.push_back(mk(0, 1, 1, 1, a(9), b(5), 2'b10, 1, b(5), 0, 1, 3));
    vecs.push_back(mk(0, 1, 1, 1, a(9), b(6), 2'b00, 0, 0,    0, 0, -1));
    vecs.push_back(mk(0, 1, 1, 1, a(9), b(6), 2'b01, 1, a(9), 1, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; m0_valid = vecs[i].v0; m1_valid = vecs[i].v1;
      s_ready = vecs[i].sr; m0_data = vecs[i].d0; m1_data = vecs[i].d1;
      #1;
      chk("grant", i, 32'(grant), 32'(vecs[i].grant));
      chk("s_valid", i, 32'(s_valid), 32'(vecs[i].sv));
      chk("s_data", i, s_data, vecs[i].sd);
      chk("m0_ready", i, 32'(m0_ready), 32'(vecs[i].r0));
      chk("m1_ready", i, 32'(m1_ready), 32'(vecs[i].r1));
      if (vecs[i].cnt >= 0) chk("beat_cnt", i, 32'(beat_cnt), 32'(vecs[i].cnt));
      if (!rst) sample();
    end

    // Scoreboard: every requester-side transfer appears once, in order, on the slave.
    chk("sb_count", 0, 32'(n_s), 32'(n_m));
    chk("sb_m0_len", 0, 32'(got0.size()), 32'd10);
    chk("sb_m1_len", 0, 32'(got1.size()), 32'd6);
    chk("sb_exp0_len", 0, 32'(exp0.size()), 32'd10);
    chk("sb_exp1_len", 0, 32'(exp1.size()), 32'd6);
    for (int i = 0; i < 10 && i < got0.size() && i < exp0.size(); i++) begin
      chk("sb_m0_data", i, got0[i], exp0[i]);
      chk("sb_m0_order", i, got0[i], a(i));
    end
    for (int i = 0; i < 6 && i < got1.size() && i < exp1.size(); i++) begin
      chk("sb_m1_data", i, got1[i], exp1[i]);
      chk("sb_m1_order", i, got1[i], b(i));
    end

    // Reset during GNT1 after one beat: outputs drop without a clock edge.
    @(negedge clk);
    m0_valid = 1'b0; m1_valid = 1'b1; m1_data = b(6); s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_seq_grant1", 0, 32'(grant), 32'(2'b10));
    @(negedge clk);
    m1_data = b(7);
    #1 chk("rst_seq_cnt1", 0, 32'(beat_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_grant", 0, 32'(grant), 32'd0);
    chk("async_s_valid", 0, 32'(s_valid), 32'd0);
    chk("async_m0_ready", 0, 32'(m0_ready), 32'd0);
    chk("async_m1_ready", 0, 32'(m1_ready), 32'd0);
    chk("async_beat_cnt", 0, 32'(beat_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1; m0_data = a(10); s_ready = 1'b1;
    #1 chk("post_rst_idle", 0, 32'(grant), 32'd0);
    chk("b1_post_rst_idle", 0, 32'(b_grant), 32'd0);

    // MAX_BURST=1 instance alternates one beat at a time with an idle cycle between.
    begin
      logic [1:0] b1_exp [5];
      b1_exp[0] = 2'b01; b1_exp[1] = 2'b00; b1_exp[2] = 2'b10;
      b1_exp[3] = 2'b00; b1_exp[4] = 2'b01;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1;
        if (i == 0) chk("post_rst_grant0", 0, 32'(grant), 32'(2'b01));
        chk("b1_grant", i, 32'(b_grant), 32'(b1_exp[i]));
        if (b1_exp[i] != 2'b00) chk("b1_beat_cnt", i, 32'(b_beat_cnt), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of every data bus.
REQ-002 Parameter MAX_BURST, default 4, legal range 1..15: maximum beats per grant before forced release.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 m0_data  input  DATA_W  requester 0 payload.
REQ-006 m0_valid  input  1  requester 0 beat valid.
REQ-007 m0_ready  output  1  requester 0 beat accepted.
REQ-008 m1_data  input  DATA_W  requester 1 payload.
REQ-009 m1_valid  input  1  requester 1 beat valid.
REQ-010 m1_ready  output  1  requester 1 beat accepted.
REQ-011 s_data  output  DATA_W  payload to the shared slave channel.
REQ-012 s_valid  output  1  beat valid to the shared slave.
REQ-013 s_ready  input  1  shared slave ready.
REQ-014 grant  output  2  one-hot owner: 01 = requester 0, 10 = requester 1, 00 = none.
REQ-015 beat_cnt  output  4  beats transferred in the current grant.

Function
REQ-016 States: IDLE, GNT0, GNT1; one state register, grant decoded from the state.
REQ-017 Transfer on a port = valid and ready high in the same cycle; the beat moves in that cycle.
REQ-018 In GNTx: s_data = mx_data, s_valid = mx_valid, mx_ready = s_ready; other requester's ready = 0.
REQ-019 In IDLE: s_valid = 0, s_data = 0, m0_ready = m1_ready = 0.
REQ-020 IDLE -> GNT0 when only m0_valid; IDLE -> GNT1 when only m1_valid; stay IDLE when neither.
REQ-021 Both valid in IDLE: grant the requester not equal to last_owner (round-robin); last_owner updates on each entry to GNTx.
REQ-022 Grant latency: request seen in IDLE at edge N -> grant visible and first beat possible in cycle after edge N.
REQ-023 beat_cnt clears to 0 on entry to GNTx and increments by 1 on each transfer in GNTx.
REQ-024 GNTx -> IDLE when a transfer brings beat_cnt+1 to MAX_BURST (forced release).
REQ-025 GNTx -> IDLE when mx_valid is low in that state (requester done); no transfer occurs that cycle.
REQ-026 Every release passes through IDLE for exactly one cycle; no back-to-back grants without an IDLE cycle.
REQ-027 A requester holds valid and data stable until transfer; arbiter never drops a beat already accepted and never duplicates one.
REQ-028 s_ready low while granted: state and beat_cnt hold; no timeout.
REQ-029 Losing requester waits with ready = 0; it is granted on the next IDLE if still valid (no starvation: at most MAX_BURST beats of the other requester between its grants).
REQ-030 MAX_BURST = 1: every transfer forces release; requesters alternate when both keep valid high.

Reset
REQ-031 rst high: state = IDLE, last_owner = requester 1 (so requester 0 wins the first tie), beat_cnt = 0, grant = 00, s_valid = 0, m0_ready = m1_ready = 0, immediately and independent of clk.
REQ-032 rst asserted mid-grant: grant aborts, in-flight beat not counted; after rst falls, arbitration restarts from IDLE on the next posedge.

Verification
REQ-033 rst released, m0_valid = 1 only, s_ready = 1 -> grant = 01 one cycle later, 4 beats pass, then one IDLE cycle (grant = 00), then grant = 01 again.
REQ-034 m0_valid and m1_valid high together from reset, s_ready = 1, MAX_BURST = 4 -> grant sequence 01 (4 beats), 00, 10 (4 beats), 00, 01 ...; s_data matches the owner's data each beat.
REQ-035 Granted m1 sends 2 beats then drops m1_valid -> next cycle IDLE, beat_cnt = 2 at drop, then m0 granted if valid.
REQ-036 s_ready held low 5 cycles while GNT0 and m0_valid = 1 -> beat_cnt and grant frozen, m0_ready = 0, no data loss once s_ready returns.
REQ-037 rst pulsed during GNT1 after 1 beat -> grant = 00 and all ready/valid outputs 0 asynchronously; after release both valid -> grant = 01.
REQ-038 Scoreboard: count of transfers on m0 plus m1 equals count on s, payloads in order per requester.
